// File: rtl/rv32_reg_file.sv
// rv32_reg_file
//   RV32I integer register file used by the decode stage: 32 x XLEN registers,
//   two combinational read ports, one synchronous write port, x0 hardwired to
//   zero, optional write-through bypass for same-cycle writeback forwarding.
//
// Handshake: none. A write happens on every rising clk edge where rst_n=1,
//   RegWEn=1 and rsW!=0; reads are continuous and carry no valid/ready.
//
// Ports:
//   clk      in   system clock, all state updates on the rising edge
//   rst_n    in   synchronous active-low reset, clears every register
//   rsR1     in   read port 1 register address
//   rsR2     in   read port 2 register address
//   rsW      in   write register address
//   dataW    in   write data
//   RegWEn   in   write enable
//   dataR1   out  read data for rsR1 (0 when rsR1 == 0)
//   dataR2   out  read data for rsR2 (0 when rsR2 == 0)
module rv32_reg_file #(
    parameter bit WRITE_THROUGH = 1'b1,
    parameter int XLEN          = 32,
    parameter int NREGS         = 32,
    localparam int AW           = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rsR1,
    input  logic [AW-1:0]   rsR2,
    input  logic [AW-1:0]   rsW,
    input  logic [XLEN-1:0] dataW,
    input  logic            RegWEn,
    output logic [XLEN-1:0] dataR1,
    output logic [XLEN-1:0] dataR2
);

    logic [XLEN-1:0] regs [NREGS];

    // A write only counts when it will actually land on the next edge; this
    // also gates the bypass so it is off during reset and for x0.
    logic writeActive;
    assign writeActive = rst_n && RegWEn && (rsW != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeActive) begin
            regs[rsW] <= dataW;
        end
    end

    // x0 is forced to zero at the read mux, so its storage slot is never
    // observable even though it is only ever loaded with zero.
    always_comb begin
        dataR1 = '0;
        if (rsR1 != '0) begin
            if (WRITE_THROUGH && writeActive && (rsW == rsR1)) begin
                dataR1 = dataW;
            end else begin
                dataR1 = regs[rsR1];
            end
        end
    end

    always_comb begin
        dataR2 = '0;
        if (rsR2 != '0) begin
            if (WRITE_THROUGH && writeActive && (rsW == rsR2)) begin
                dataR2 = dataW;
            end else begin
                dataR2 = regs[rsR2];
            end
        end
    end

endmodule

// File: tb/tb_rv32_reg_file.sv
// tb_rv32_reg_file
//   Drives one write-through instance and one plain instance from the same
//   inputs and compares both read ports against an array model of the
//   architectural register state.
module tb_rv32_reg_file;

    localparam logic [31:0] PAT  = 32'hBABABABA;
    localparam logic [31:0] PAT2 = 32'h12345678;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  = 1'b1;
    logic [4:0]  rsR1   = '0;
    logic [4:0]  rsR2   = '0;
    logic [4:0]  rsW    = '0;
    logic [31:0] dataW  = '0;
    logic        RegWEn = 1'b0;
    logic [31:0] r1Wt, r2Wt, r1Nb, r2Nb;

    rv32_reg_file #(.WRITE_THROUGH(1'b1)) dutWt (
        .clk(clk), .rst_n(rst_n), .rsR1(rsR1), .rsR2(rsR2), .rsW(rsW),
        .dataW(dataW), .RegWEn(RegWEn), .dataR1(r1Wt), .dataR2(r2Wt)
    );

    rv32_reg_file #(.WRITE_THROUGH(1'b0)) dutNb (
        .clk(clk), .rst_n(rst_n), .rsR1(rsR1), .rsR2(rsR2), .rsW(rsW),
        .dataW(dataW), .RegWEn(RegWEn), .dataR1(r1Nb), .dataR2(r2Nb)
    );

    // reference model and scoreboard
    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    int checks   = 0;
    int failures = 0;

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
    end

    // Architectural read value seen by a port at address a right now.
    function automatic logic [31:0] expRead(input logic [4:0] a, input bit wt);
        if (a == 5'd0) return 32'd0;
        if (wt && rst_n && RegWEn && rsW != 5'd0 && rsW == a) return dataW;
        return model[a];
    endfunction

    // driver: advance one clock, applying the architectural update to the model
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (RegWEn && rsW != 5'd0) begin
            model[rsW] = dataW;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; RegWEn = 1'b0;
        tick(); tick();
        rst_n = 1'b1; rsR1 = 5'd3; rsR2 = 5'd3;
        #2;
        checks++; if (r1Wt !== 32'd0) begin failures++; $display("FAIL reset_r1_wt: got %h expected 0", r1Wt); end
        checks++; if (r2Wt !== 32'd0) begin failures++; $display("FAIL reset_r2_wt: got %h expected 0", r2Wt); end
        checks++; if (r1Nb !== 32'd0) begin failures++; $display("FAIL reset_r1_nb: got %h expected 0", r1Nb); end
        checks++; if (r2Nb !== 32'd0) begin failures++; $display("FAIL reset_r2_nb: got %h expected 0", r2Nb); end
        for (int a = 0; a < 32; a++) begin
            rsR1 = a[4:0]; rsR2 = 5'(31 - a);
            #1;
            checks++;
            if (r1Wt !== 32'd0 || r2Wt !== 32'd0 || r1Nb !== 32'd0 || r2Nb !== 32'd0) begin
                failures++;
                $display("FAIL reset_sweep x%0d: got %h %h %h %h expected 0", a, r1Wt, r2Wt, r1Nb, r2Nb);
            end
        end
    endtask

    task automatic test_write_x0();
        RegWEn = 1'b1; rsW = 5'd0; dataW = PAT; rsR1 = 5'd0; rsR2 = 5'd0;
        #2;
        checks++; if (r1Wt !== 32'd0 || r1Nb !== 32'd0) begin failures++; $display("FAIL x0_before_edge: got %h %h expected 0", r1Wt, r1Nb); end
        tick();
        checks++; if (r1Wt !== 32'd0 || r1Nb !== 32'd0) begin failures++; $display("FAIL x0_after_edge: got %h %h expected 0", r1Wt, r1Nb); end
        RegWEn = 1'b0;
        for (int a = 1; a < 32; a++) begin
            rsR1 = a[4:0]; rsR2 = a[4:0];
            #1;
            checks++;
            if (r1Wt !== 32'd0 || r2Nb !== 32'd0) begin
                failures++;
                $display("FAIL x0_others x%0d: got %h %h expected 0", a, r1Wt, r2Nb);
            end
        end
    endtask

    task automatic test_disabled_write();
        RegWEn = 1'b0; rsW = 5'd3; dataW = PAT; rsR1 = 5'd3; rsR2 = 5'd3;
        #2;
        checks++; if (r1Wt !== 32'd0) begin failures++; $display("FAIL disabled_no_bypass: got %h expected 0", r1Wt); end
        tick(); tick();
        checks++; if (r1Wt !== 32'd0 || r2Nb !== 32'd0) begin failures++; $display("FAIL disabled_write: got %h %h expected 0", r1Wt, r2Nb); end
    endtask

    task automatic test_write_read();
        RegWEn = 1'b1; rsW = 5'd3; dataW = PAT; rsR1 = 5'd3; rsR2 = 5'd3;
        #2;
        checks++; if (r1Wt !== PAT || r2Wt !== PAT) begin failures++; $display("FAIL wr_bypass_wt: got %h %h expected %h", r1Wt, r2Wt, PAT); end
        checks++; if (r1Nb !== 32'd0 || r2Nb !== 32'd0) begin failures++; $display("FAIL wr_old_nb: got %h %h expected 0", r1Nb, r2Nb); end
        tick();
        RegWEn = 1'b0;
        #1;
        checks++; if (r1Wt !== PAT || r2Wt !== PAT) begin failures++; $display("FAIL wr_after_wt: got %h %h expected %h", r1Wt, r2Wt, PAT); end
        checks++; if (r1Nb !== PAT || r2Nb !== PAT) begin failures++; $display("FAIL wr_after_nb: got %h %h expected %h", r1Nb, r2Nb, PAT); end
    endtask

    task automatic test_same_cycle();
        rsR1 = 5'd4; rsR2 = 5'd5; RegWEn = 1'b1; dataW = PAT; rsW = 5'd4;
        #2;
        checks++; if (r1Wt !== PAT)    begin failures++; $display("FAIL sc_x4_wt_in_cycle: got %h expected %h", r1Wt, PAT); end
        checks++; if (r1Nb !== 32'd0)  begin failures++; $display("FAIL sc_x4_nb_in_cycle: got %h expected 0", r1Nb); end
        checks++; if (r2Wt !== 32'd0 || r2Nb !== 32'd0) begin failures++; $display("FAIL sc_x5_early: got %h %h expected 0", r2Wt, r2Nb); end
        tick();
        rsW = 5'd5;
        #2;
        checks++; if (r1Nb !== PAT)    begin failures++; $display("FAIL sc_x4_nb_after: got %h expected %h", r1Nb, PAT); end
        checks++; if (r2Wt !== PAT)    begin failures++; $display("FAIL sc_x5_wt_in_cycle: got %h expected %h", r2Wt, PAT); end
        checks++; if (r2Nb !== 32'd0)  begin failures++; $display("FAIL sc_x5_nb_in_cycle: got %h expected 0", r2Nb); end
        tick();
        RegWEn = 1'b0;
        #1;
        checks++; if (r2Nb !== PAT || r2Wt !== PAT) begin failures++; $display("FAIL sc_x5_after: got %h %h expected %h", r2Wt, r2Nb, PAT); end
        // both ports bypassing the same target at once
        RegWEn = 1'b1; rsW = 5'd9; dataW = PAT2; rsR1 = 5'd9; rsR2 = 5'd9;
        #2;
        checks++; if (r1Wt !== PAT2 || r2Wt !== PAT2) begin failures++; $display("FAIL dual_bypass: got %h %h expected %h", r1Wt, r2Wt, PAT2); end
        tick();
        RegWEn = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        RegWEn = 1'b1; rsW = 5'd3; dataW = PAT; tick();  // make sure x3 holds PAT
        RegWEn = 1'b1; rsW = 5'd7; dataW = PAT2; rst_n = 1'b0; rsR1 = 5'd7; rsR2 = 5'd3;
        #2;
        checks++; if (r1Wt !== 32'd0)  begin failures++; $display("FAIL rst_no_bypass: got %h expected 0", r1Wt); end
        checks++; if (r2Wt !== PAT || r2Nb !== PAT) begin failures++; $display("FAIL rst_before_edge: got %h %h expected %h", r2Wt, r2Nb, PAT); end
        tick();
        rst_n = 1'b1; RegWEn = 1'b0;
        #1;
        checks++; if (r1Wt !== 32'd0 || r1Nb !== 32'd0) begin failures++; $display("FAIL rst_x7_cleared: got %h %h expected 0", r1Wt, r1Nb); end
        checks++; if (r2Wt !== 32'd0 || r2Nb !== 32'd0) begin failures++; $display("FAIL rst_x3_cleared: got %h %h expected 0", r2Wt, r2Nb); end
    endtask

    task automatic test_random();
        logic [31:0] got [4];
        for (int n = 0; n < 400; n++) begin
            rst_n  = ($urandom_range(0, 39) != 0);
            RegWEn = ($urandom_range(0, 3) != 0);
            rsW    = 5'($urandom_range(0, 31));
            dataW  = $urandom;
            rsR1   = ($urandom_range(0, 2) == 0) ? rsW : 5'($urandom_range(0, 31));
            rsR2   = ($urandom_range(0, 2) == 0) ? rsW : 5'($urandom_range(0, 31));
            #2;
            exp_q.push_back(expRead(rsR1, 1'b1));
            exp_q.push_back(expRead(rsR2, 1'b1));
            exp_q.push_back(expRead(rsR1, 1'b0));
            exp_q.push_back(expRead(rsR2, 1'b0));
            got[0] = r1Wt; got[1] = r2Wt; got[2] = r1Nb; got[3] = r2Nb;
            for (int k = 0; k < 4; k++) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                checks++;
                if (got[k] !== e) begin
                    failures++;
                    $display("FAIL random n=%0d port%0d rsR1=%0d rsR2=%0d rsW=%0d we=%0b rst_n=%0b: got %h expected %h",
                             n, k, rsR1, rsR2, rsW, RegWEn, rst_n, got[k], e);
                end
            end
            tick();
        end
        rst_n = 1'b1; RegWEn = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_write_x0();
        test_disabled_write();
        test_write_read();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
